// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX branch flush, mul/div freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MD_TIMEOUT        = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  ex_md_start,
    input  logic                  ex_md_done,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_hold,
    output logic [1:0]            state_o,
    output logic                  md_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam int MDW = $clog2(MD_TIMEOUT + 1);
    localparam logic [MDW-1:0] MD_LIM  = MDW'(MD_TIMEOUT);
    localparam logic [2:0]     LD_INIT = 3'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_LD   = 2'b01,
        S_MD   = 2'b10,
        S_BAD  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     ld_cnt_q, ld_cnt_d;
    logic [MDW-1:0] md_cnt_q, md_cnt_d;
    logic           md_timeout_q, md_timeout_d;
    logic           hazard;

    always_comb begin
        hazard = ex_mem_read && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_hold      = 1'b0;

        case (state_q)
            S_RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_md_start) begin
                    // A unit that finishes in its start cycle needs no freeze at all
                    if (!ex_md_done) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        ex_hold  = 1'b1;
                        state_d  = S_MD;
                        md_cnt_d = MDW'(1);
                    end
                end else if (hazard) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d  = S_LD;
                        ld_cnt_d = LD_INIT;
                    end
                end
            end
            S_LD: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                if (ld_cnt_q <= 3'd1) state_d  = S_RUN;
                else                  ld_cnt_d = ld_cnt_q - 3'd1;
            end
            S_MD: begin
                if (ex_md_done) begin
                    state_d = S_RUN;
                end else if (md_cnt_q >= MD_LIM) begin
                    // Give up on the unit: release the pipeline exactly as a done would
                    md_timeout_d = 1'b1;
                    state_d      = S_RUN;
                end else begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    ex_hold  = 1'b1;
                    if (md_cnt_q != '1) md_cnt_d = md_cnt_q + MDW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase

        if (!reset_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_hold     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RUN;
            ld_cnt_q     <= '0;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign state_o    = state_q;
    assign md_timeout = md_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic        branch_flush;

    assign branch_flush = (state_q == S_RUN) && ex_branch_taken;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (branch_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LSC=1/MDT=8 and LSC=2/MDT=5) share stimulus;
// directed table, hand sequences, then random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int LSC_A = 1, MDT_A = 8;
    localparam int LSC_B = 2, MDT_B = 5;

    localparam logic [5:0] RUNV   = 6'b110100;
    localparam logic [5:0] STALLV = 6'b000110;
    localparam logic [5:0] BRV    = 6'b111110;
    localparam logic [5:0] HOLDV  = 6'b000001;
    localparam logic [5:0] RSTV   = 6'b001010;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_md_start, ex_md_done;

    logic pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a, ex_hold_a, tmo_a;
    logic pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b, ex_hold_b, tmo_b;
    logic [1:0] st_a, st_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif
    logic [5:0] obs_a, obs_b;
    assign obs_a = {pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a, ex_hold_a};
    assign obs_b = {pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b, ex_hold_b};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC_A), .MD_TIMEOUT(MDT_A)) dut_a (
        .clk(clk), .reset_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .ex_md_done(ex_md_done), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
        .if_id_flush(if_id_flush_a), .id_ex_en(id_ex_en_a), .id_ex_flush(id_ex_flush_a),
        .ex_hold(ex_hold_a), .state_o(st_a), .md_timeout(tmo_a)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc_a), .flush_cnt(fc_a)
`endif
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC_B), .MD_TIMEOUT(MDT_B)) dut_b (
        .clk(clk), .reset_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .ex_md_done(ex_md_done), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
        .if_id_flush(if_id_flush_b), .id_ex_en(id_ex_en_b), .id_ex_flush(id_ex_flush_b),
        .ex_hold(ex_hold_b), .state_o(st_b), .md_timeout(tmo_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc_b), .flush_cnt(fc_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: mode 0 run, 1 inserting extra bubbles, 2 waiting on mul/div.
    int         m_mode[2], m_bubbles_left[2], m_md_waited[2];
    int         n_mode[2], n_bubbles_left[2], n_md_waited[2];
    bit         m_tmo[2], n_tmo[2], n_brf[2];
    logic [5:0] m_exp[2];
    logic [31:0] m_sc[2], m_fc[2];

    function automatic int lsc_of(input int i); return (i == 0) ? LSC_A : LSC_B; endfunction
    function automatic int mdt_of(input int i); return (i == 0) ? MDT_A : MDT_B; endfunction

    task automatic model_reset(input int i);
        m_mode[i] = 0; m_bubbles_left[i] = 0; m_md_waited[i] = 0; m_tmo[i] = 0;
        m_sc[i] = 0; m_fc[i] = 0;
    endtask

    task automatic model_eval(input int i);
        bit hz;
        hz = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        m_exp[i] = RUNV;
        n_mode[i] = m_mode[i]; n_bubbles_left[i] = m_bubbles_left[i];
        n_md_waited[i] = m_md_waited[i]; n_tmo[i] = m_tmo[i]; n_brf[i] = 0;
        if (!rst_n) begin
            m_exp[i] = RSTV;
        end else if (m_mode[i] == 0) begin
            if (ex_branch_taken) begin
                m_exp[i] = BRV; n_brf[i] = 1;
            end else if (ex_md_start) begin
                if (!ex_md_done) begin
                    m_exp[i] = HOLDV; n_mode[i] = 2; n_md_waited[i] = 1;
                end
            end else if (hz) begin
                m_exp[i] = STALLV;
                if (lsc_of(i) > 1) begin n_mode[i] = 1; n_bubbles_left[i] = lsc_of(i) - 1; end
            end
        end else if (m_mode[i] == 1) begin
            m_exp[i] = STALLV;
            if (m_bubbles_left[i] == 1) n_mode[i] = 0;
            else n_bubbles_left[i] = m_bubbles_left[i] - 1;
        end else begin
            if (ex_md_done) n_mode[i] = 0;
            else if (m_md_waited[i] >= mdt_of(i)) begin n_tmo[i] = 1; n_mode[i] = 0; end
            else begin m_exp[i] = HOLDV; n_md_waited[i] = m_md_waited[i] + 1; end
        end
    endtask

    task automatic model_commit(input int i);
        if (m_exp[i][5] == 1'b0 && m_sc[i] != 32'hFFFF_FFFF) m_sc[i]++;
        if (n_brf[i] && m_fc[i] != 32'hFFFF_FFFF) m_fc[i]++;
        m_mode[i] = n_mode[i]; m_bubbles_left[i] = n_bubbles_left[i];
        m_md_waited[i] = n_md_waited[i]; m_tmo[i] = n_tmo[i];
    endtask

    // One clock: inputs already set after a negedge; compare, cross posedge, return at next negedge.
    task automatic cyc(input bit chk_a, input logic [5:0] ea, input logic [1:0] sa);
        #1;
        if (!rst_n) begin model_reset(0); model_reset(1); end
        for (int i = 0; i < 2; i++) model_eval(i);
        chk("outs_a", 32'(obs_a), 32'(m_exp[0]));
        chk("outs_b", 32'(obs_b), 32'(m_exp[1]));
        chk("state_a", 32'(st_a), 32'(m_mode[0]));
        chk("state_b", 32'(st_b), 32'(m_mode[1]));
        chk("tmo_a", 32'(tmo_a), 32'(m_tmo[0]));
        chk("tmo_b", 32'(tmo_b), 32'(m_tmo[1]));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt_a", sc_a, m_sc[0]); chk("flush_cnt_a", fc_a, m_fc[0]);
        chk("stall_cnt_b", sc_b, m_sc[1]); chk("flush_cnt_b", fc_b, m_fc[1]);
`endif
        if (chk_a) begin
            chk("dir_outs_a", 32'(obs_a), 32'(ea));
            chk("dir_state_a", 32'(st_a), 32'(sa));
        end
        @(posedge clk);
        if (rst_n) for (int i = 0; i < 2; i++) model_commit(i);
        @(negedge clk);
    endtask

    task automatic idle();
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_branch_taken = 0; ex_md_start = 0; ex_md_done = 0;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0; cyc(1, RSTV, 2'b00); rst_n = 1;
    endtask

    typedef struct {
        logic       br, start, done, mr, u1, u2;
        logic [4:0] rd, rs1, rs2;
        logic [5:0] exp_a;
        logic [1:0] st_a;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic br, start, done, mr, u1, u2,
                                input logic [4:0] rd, rs1, rs2,
                                input logic [5:0] e, input logic [1:0] s);
        vec_t v;
        v.br = br; v.start = start; v.done = done; v.mr = mr; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.exp_a = e; v.st_a = s;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RUNV,   2'b00);
        vecs[1] = mk(0, 0, 0, 1, 0, 1, 5'd5, 5'd0, 5'd5, STALLV, 2'b00);
        vecs[2] = mk(0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, RUNV,   2'b00);
        vecs[3] = mk(0, 0, 0, 1, 0, 0, 5'd5, 5'd0, 5'd5, RUNV,   2'b00);
        vecs[4] = mk(0, 0, 0, 1, 1, 0, 5'd7, 5'd7, 5'd1, STALLV, 2'b00);
        vecs[5] = mk(1, 0, 0, 1, 0, 1, 5'd5, 5'd0, 5'd5, BRV,    2'b00);
        vecs[6] = mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RUNV,   2'b00);
        vecs[7] = mk(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, RUNV,   2'b00);
        vecs[8] = mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, RUNV,   2'b00);

        idle(); rst_n = 0;
        model_reset(0); model_reset(1);
        @(negedge clk);
        cyc(1, RSTV, 2'b00);
        rst_n = 1;

        foreach (vecs[k]) begin
            ex_branch_taken = vecs[k].br; ex_md_start = vecs[k].start; ex_md_done = vecs[k].done;
            ex_mem_read = vecs[k].mr; id_uses_rs1 = vecs[k].u1; id_uses_rs2 = vecs[k].u2;
            ex_rd = vecs[k].rd; id_rs1 = vecs[k].rs1; id_rs2 = vecs[k].rs2;
            cyc(1, vecs[k].exp_a, vecs[k].st_a);
        end

        // Two-bubble load-use on the LSC=2 instance
        do_reset(); idle();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        cyc(0, RUNV, 2'b00);
        idle();
        #1; chk("lsc2_stall2", 32'(obs_b), 32'(STALLV)); chk("lsc2_state", 32'(st_b), 32'h1);
        cyc(0, RUNV, 2'b00);
        #1; chk("lsc2_done", 32'(obs_b), 32'(RUNV)); chk("lsc2_state_run", 32'(st_b), 32'h0);
        cyc(0, RUNV, 2'b00);

        // Mul/div done after 6 cycles, then one branch
        do_reset(); idle();
        ex_md_start = 1; cyc(1, HOLDV, 2'b00);
        ex_md_start = 0;
        for (int c = 1; c < 6; c++) cyc(1, HOLDV, 2'b10);
        ex_md_done = 1; cyc(1, RUNV, 2'b10);
        ex_md_done = 0; cyc(1, RUNV, 2'b00);
        ex_branch_taken = 1; cyc(1, BRV, 2'b00);
        ex_branch_taken = 0;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall6", sc_a, 32'd6);
        chk("perf_flush1", fc_a, 32'd1);
`endif

        // Timeout: MDT=8 on instance a, sticky flag until reset
        do_reset(); idle();
        ex_md_start = 1; cyc(1, HOLDV, 2'b00);
        ex_md_start = 0;
        for (int c = 1; c < 8; c++) cyc(1, HOLDV, 2'b10);
        cyc(1, RUNV, 2'b10);
        chk("tmo_set", 32'(tmo_a), 32'h1);
        for (int c = 0; c < 3; c++) cyc(1, RUNV, 2'b00);
        chk("tmo_sticky", 32'(tmo_a), 32'h1);

        // Async reset in the middle of MD_WAIT
        ex_md_start = 1; cyc(1, HOLDV, 2'b00);
        ex_md_start = 0; cyc(1, HOLDV, 2'b10); cyc(1, HOLDV, 2'b10);
        rst_n = 0;
        #2;
        chk("rst_async_outs", 32'(obs_a), 32'(RSTV));
        chk("rst_async_state", 32'(st_a), 32'h0);
        chk("rst_tmo_clear", 32'(tmo_a), 32'h0);
        @(negedge clk);
        cyc(1, RSTV, 2'b00);
        rst_n = 1;
        cyc(1, RUNV, 2'b00);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            ex_md_start     = ($urandom_range(0, 11) == 0);
            ex_md_done      = ($urandom_range(0, 7) == 0);
            cyc(0, RUNV, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
